// File: rtl/qpix_pkg.sv
// qpix_pkg: shared readout FSM encoding and default geometry for the Q-Pix serial readout
package qpix_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_HI,
        SHIFT_LO,
        DONE
    } state_t;

    localparam int NBITS_DEF    = 32;
    localparam int DIV_DEF      = 4;
    localparam int LOAD_CYC_DEF = 2;

endpackage

// File: rtl/sync2ff.sv
// sync2ff: two-flop synchronizer bringing an asynchronous ASIC data line into the clk domain
module sync2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // first flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge clk) begin
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/qpix_readout_sipo.sv
// qpix_readout_sipo: strobes the ASIC parallel load, clocks out two serial words and presents them in parallel
module qpix_readout_sipo
    import qpix_pkg::*;
#(
    parameter int NBITS    = NBITS_DEF,
    parameter int DIV      = DIV_DEF,
    parameter int LOAD_CYC = LOAD_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             data_out1,
    input  logic             data_out2,
    output logic             clk_out,
    output logic             serial_out_cnt,
    output logic [NBITS-1:0] word1,
    output logic [NBITS-1:0] word2,
    output logic             done,
    output logic             busy,
    output logic             start_drop
);

    localparam int BW = $clog2(NBITS + 1);

    state_t           state;
    logic [7:0]       cnt;
    logic [BW-1:0]    bit_cnt;
    logic [NBITS-1:0] sr1;
    logic [NBITS-1:0] sr2;
    logic             d1;
    logic             d2;

    sync2ff u_sync1 (.clk(clk), .rst(rst), .d(data_out1), .q(d1));
    sync2ff u_sync2 (.clk(clk), .rst(rst), .d(data_out2), .q(d2));

    // readout sequencer; every pad-facing output is a flop updated alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_cnt        <= '0;
            sr1            <= '0;
            sr2            <= '0;
            word1          <= '0;
            word2          <= '0;
            clk_out        <= 1'b0;
            serial_out_cnt <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
            start_drop     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && state != IDLE && state != DONE) start_drop <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= LOAD;
                        serial_out_cnt <= 1'b1;
                        busy           <= 1'b1;
                        cnt            <= '0;
                        sr1            <= '0;
                        sr2            <= '0;
                    end
                end
                LOAD: begin
                    if (cnt == 8'(LOAD_CYC - 1)) begin
                        state          <= SHIFT_HI;
                        serial_out_cnt <= 1'b0;
                        clk_out        <= 1'b1;
                        cnt            <= '0;
                        bit_cnt        <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (cnt == 8'(DIV - 1)) begin
                        state   <= SHIFT_LO;
                        clk_out <= 1'b0;
                        cnt     <= '0;
                        sr1     <= {sr1[NBITS-2:0], d1};
                        sr2     <= {sr2[NBITS-2:0], d2};
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHIFT_LO: begin
                    if (cnt == 8'(DIV - 1)) begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(NBITS - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            word1 <= sr1;
                            word2 <= sr2;
                        end else begin
                            state   <= SHIFT_HI;
                            clk_out <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
